// File: rtl/os_pe_drain.sv
// Output-stationary MAC processing element with valid/last tile framing,
// signed/unsigned operand mode, optional saturation and a per-column drain chain.
module os_pe_drain #(
    parameter int IP_DATA_WIDTH = 8,
    parameter int OP_DATA_WIDTH = 32,
    parameter int SATURATE      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     signed_mode,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [IP_DATA_WIDTH-1:0] in_data_0,
    input  logic [IP_DATA_WIDTH-1:0] in_data_1,
    output logic                     out_valid,
    output logic [IP_DATA_WIDTH-1:0] out_data_0,
    output logic [IP_DATA_WIDTH-1:0] out_data_1,
    output logic [OP_DATA_WIDTH-1:0] pe_out_reg,
    output logic                     done,
    output logic                     sat,
    output logic                     overrun,
    input  logic                     drain_en,
    input  logic                     drain_in_valid,
    input  logic [OP_DATA_WIDTH-1:0] drain_in_data,
    output logic                     drain_out_valid,
    output logic [OP_DATA_WIDTH-1:0] drain_out_data
);

    localparam int PW    = 2 * IP_DATA_WIDTH;
    localparam int EXT_W = OP_DATA_WIDTH + 1 - PW;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_HOLD = 2'd1,
        ST_PASS = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_first;
    logic                       r_signed;
    logic                       r_out_valid;
    logic [IP_DATA_WIDTH-1:0]   r_out_d0;
    logic [IP_DATA_WIDTH-1:0]   r_out_d1;
    logic [OP_DATA_WIDTH-1:0]   r_acc;
    logic                       r_done;
    logic                       r_sat;
    logic                       r_overrun;
    logic                       r_drain_vld;
    logic [OP_DATA_WIDTH-1:0]   r_drain_data;

    logic                       w_acc_en;
    logic                       w_load_own;
    logic                       w_pass;
    logic                       w_to_acc;
    logic                       w_overrun_set;

    logic                       w_tile_signed;
    logic signed [IP_DATA_WIDTH:0] w_a_ext;
    logic signed [IP_DATA_WIDTH:0] w_b_ext;
    logic signed [PW-1:0]       w_prod;
    logic [OP_DATA_WIDTH:0]     w_prod_ext;
    logic [OP_DATA_WIDTH:0]     w_acc_ext;
    logic [OP_DATA_WIDTH:0]     w_sum;
    logic                       w_ovf;
    logic [OP_DATA_WIDTH-1:0]   w_acc_nxt;

    // Overflow of the OP_DATA_WIDTH+1 bit sum: carry-out when unsigned,
    // disagreement of the two top bits when signed.
    function automatic logic f_overflow(input logic [OP_DATA_WIDTH:0] sum,
                                        input logic is_signed);
        if (is_signed)
            return sum[OP_DATA_WIDTH] ^ sum[OP_DATA_WIDTH-1];
        return sum[OP_DATA_WIDTH];
    endfunction

    function automatic logic [OP_DATA_WIDTH-1:0] f_resolve(input logic [OP_DATA_WIDTH:0] sum,
                                                           input logic is_signed,
                                                           input logic ovf);
        if (!ovf || (SATURATE == 0))
            return sum[OP_DATA_WIDTH-1:0];
        if (!is_signed)
            return {OP_DATA_WIDTH{1'b1}};
        // Sign of the true result is the extra top bit.
        if (sum[OP_DATA_WIDTH])
            return {1'b1, {(OP_DATA_WIDTH-1){1'b0}}};
        return {1'b0, {(OP_DATA_WIDTH-1){1'b1}}};
    endfunction

    // Signedness is latched on the first pair of a tile; that pair uses the live input.
    assign w_tile_signed = r_first ? signed_mode : r_signed;
    assign w_a_ext       = {w_tile_signed & in_data_0[IP_DATA_WIDTH-1], in_data_0};
    assign w_b_ext       = {w_tile_signed & in_data_1[IP_DATA_WIDTH-1], in_data_1};
    assign w_prod        = w_a_ext * w_b_ext;
    assign w_prod_ext    = {{EXT_W{w_tile_signed & w_prod[PW-1]}}, w_prod};
    assign w_acc_ext     = r_first ? '0 : {w_tile_signed & r_acc[OP_DATA_WIDTH-1], r_acc};
    assign w_sum         = w_acc_ext + w_prod_ext;
    assign w_ovf         = f_overflow(w_sum, w_tile_signed);
    assign w_acc_nxt     = f_resolve(w_sum, w_tile_signed, w_ovf);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_ACC;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_en      = 1'b0;
        w_load_own    = 1'b0;
        w_pass        = 1'b0;
        w_to_acc      = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_ACC: begin
                if (in_valid) begin
                    w_acc_en = 1'b1;
                    if (in_last)
                        w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_overrun_set = in_valid;
                if (drain_en) begin
                    w_load_own  = 1'b1;
                    w_state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                w_overrun_set = in_valid;
                if (drain_en) begin
                    w_pass = 1'b1;
                end else begin
                    w_to_acc    = 1'b1;
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    // Operand forwarding runs independently of the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_d0    <= '0;
            r_out_d1    <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_d0 <= in_data_0;
                r_out_d1 <= in_data_1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_first   <= 1'b1;
            r_signed  <= 1'b0;
            r_done    <= 1'b0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_acc_en) begin
                r_acc   <= w_acc_nxt;
                r_sat   <= (r_first ? 1'b0 : r_sat) | w_ovf;
                r_first <= 1'b0;
                if (r_first)
                    r_signed <= signed_mode;
                if (in_last)
                    r_done <= 1'b1;
            end
            if (w_load_own)
                r_done <= 1'b0;
            if (w_to_acc)
                r_first <= 1'b1;
            if (w_overrun_set)
                r_overrun <= 1'b1;
        end
    end

    // Drain chain: own result on the first drain cycle, then one stage of pass-through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drain_vld  <= 1'b0;
            r_drain_data <= '0;
        end else begin
            r_drain_vld <= w_load_own | (w_pass & drain_in_valid);
            if (w_load_own)
                r_drain_data <= r_acc;
            else if (w_pass)
                r_drain_data <= drain_in_data;
        end
    end

    assign out_valid       = r_out_valid;
    assign out_data_0      = r_out_d0;
    assign out_data_1      = r_out_d1;
    assign pe_out_reg      = r_acc;
    assign done            = r_done;
    assign sat             = r_sat;
    assign overrun         = r_overrun;
    assign drain_out_valid = r_drain_vld;
    assign drain_out_data  = r_drain_data;

endmodule

// File: tb/tb_os_pe_drain.sv
// Directed testbench for os_pe_drain: head/tail column pair plus 16-bit
// saturating and wrapping instances.
module tb_os_pe_drain;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // head/tail column (32-bit, saturating)
    logic        sm;
    logic        den;
    logic        m_vld, m_last;
    logic [7:0]  m_d0, m_d1;
    logic        t_vld, t_last;
    logic [7:0]  t_d0, t_d1;
    logic        m_ov, m_done, m_sat, m_overrun, m_dov;
    logic [7:0]  m_o0, m_o1;
    logic [31:0] m_acc, m_dod;
    logic        t_ov, t_done, t_sat, t_overrun, t_dov;
    logic [7:0]  t_o0, t_o1;
    logic [31:0] t_acc, t_dod;

    // 16-bit instances sharing one stimulus
    logic        x_sm, x_vld, x_last;
    logic [7:0]  x_d0, x_d1;
    logic        s_ov, s_done, s_sat, s_overrun, s_dov;
    logic [7:0]  s_o0, s_o1;
    logic [15:0] s_acc, s_dod;
    logic        w_ov, w_done, w_sat, w_overrun, w_dov;
    logic [7:0]  w_o0, w_o1;
    logic [15:0] w_acc, w_dod;

    os_pe_drain #(.IP_DATA_WIDTH(8), .OP_DATA_WIDTH(32), .SATURATE(1)) u_head (
        .clk(clk), .rst_n(rst_n), .signed_mode(sm),
        .in_valid(m_vld), .in_last(m_last), .in_data_0(m_d0), .in_data_1(m_d1),
        .out_valid(m_ov), .out_data_0(m_o0), .out_data_1(m_o1),
        .pe_out_reg(m_acc), .done(m_done), .sat(m_sat), .overrun(m_overrun),
        .drain_en(den), .drain_in_valid(t_dov), .drain_in_data(t_dod),
        .drain_out_valid(m_dov), .drain_out_data(m_dod)
    );

    os_pe_drain #(.IP_DATA_WIDTH(8), .OP_DATA_WIDTH(32), .SATURATE(1)) u_tail (
        .clk(clk), .rst_n(rst_n), .signed_mode(sm),
        .in_valid(t_vld), .in_last(t_last), .in_data_0(t_d0), .in_data_1(t_d1),
        .out_valid(t_ov), .out_data_0(t_o0), .out_data_1(t_o1),
        .pe_out_reg(t_acc), .done(t_done), .sat(t_sat), .overrun(t_overrun),
        .drain_en(den), .drain_in_valid(1'b0), .drain_in_data(32'd0),
        .drain_out_valid(t_dov), .drain_out_data(t_dod)
    );

    os_pe_drain #(.IP_DATA_WIDTH(8), .OP_DATA_WIDTH(16), .SATURATE(1)) u_sat16 (
        .clk(clk), .rst_n(rst_n), .signed_mode(x_sm),
        .in_valid(x_vld), .in_last(x_last), .in_data_0(x_d0), .in_data_1(x_d1),
        .out_valid(s_ov), .out_data_0(s_o0), .out_data_1(s_o1),
        .pe_out_reg(s_acc), .done(s_done), .sat(s_sat), .overrun(s_overrun),
        .drain_en(1'b0), .drain_in_valid(1'b0), .drain_in_data(16'd0),
        .drain_out_valid(s_dov), .drain_out_data(s_dod)
    );

    os_pe_drain #(.IP_DATA_WIDTH(8), .OP_DATA_WIDTH(16), .SATURATE(0)) u_wrap16 (
        .clk(clk), .rst_n(rst_n), .signed_mode(x_sm),
        .in_valid(x_vld), .in_last(x_last), .in_data_0(x_d0), .in_data_1(x_d1),
        .out_valid(w_ov), .out_data_0(w_o0), .out_data_1(w_o1),
        .pe_out_reg(w_acc), .done(w_done), .sat(w_sat), .overrun(w_overrun),
        .drain_en(1'b0), .drain_in_valid(1'b0), .drain_in_data(16'd0),
        .drain_out_valid(w_dov), .drain_out_data(w_dod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        m_vld = 0; m_last = 0; m_d0 = 0; m_d1 = 0;
        t_vld = 0; t_last = 0; t_d0 = 0; t_d1 = 0;
        x_vld = 0; x_last = 0; x_d0 = 0; x_d1 = 0;
        den = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drive_x(input logic [7:0] a, input logic [7:0] b, input logic last);
        x_vld = 1; x_d0 = a; x_d1 = b; x_last = last;
        tick();
        x_vld = 0; x_last = 0;
    endtask

    task automatic test_reset();
        sm = 0; x_sm = 0;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_ov, m_o0, m_o1, m_acc, m_done, m_sat, m_overrun, m_dov, m_dod} !== '0) begin
            failures++;
            $display("FAIL reset_outputs acc=%h done=%b dov=%b dod=%h", m_acc, m_done, m_dov, m_dod);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if ({m_acc, m_done, m_sat, m_overrun} !== '0) begin
            failures++;
            $display("FAIL reset_release acc=%h done=%b sat=%b ovr=%b", m_acc, m_done, m_sat, m_overrun);
        end
    endtask

    task automatic test_unsigned_tile();
        sm = 0;
        for (int k = 1; k <= 8; k++) begin
            m_vld = 1; m_d0 = 8'(k); m_d1 = 8'(k); m_last = (k == 8);
            tick();
            checks++;
            if (m_ov !== 1'b1 || m_o0 !== 8'(k) || m_o1 !== 8'(k)) begin
                failures++;
                $display("FAIL fwd_%0d got v=%b d0=%0d d1=%0d exp v=1 d0=%0d d1=%0d", k, m_ov, m_o0, m_o1, k, k);
            end
        end
        m_vld = 0; m_last = 0;
        checks++;
        if (m_acc !== 32'd204 || m_done !== 1'b1 || m_sat !== 1'b0) begin
            failures++;
            $display("FAIL unsigned_tile acc=%0d done=%b sat=%b exp 204 1 0", m_acc, m_done, m_sat);
        end
        tick();
        checks++;
        if (m_ov !== 1'b0 || m_acc !== 32'd204 || m_o0 !== 8'd8) begin
            failures++;
            $display("FAIL hold_after_tile v=%b acc=%0d d0=%0d exp 0 204 8", m_ov, m_acc, m_o0);
        end
    endtask

    task automatic test_drain_column();
        t_vld = 1; t_d0 = 8'd10; t_d1 = 8'd10; t_last = 1;
        tick();
        t_vld = 0; t_last = 0;
        checks++;
        if (t_acc !== 32'd100 || t_done !== 1'b1) begin
            failures++;
            $display("FAIL tail_single_pair acc=%0d done=%b exp 100 1", t_acc, t_done);
        end
        den = 1;
        tick();
        checks++;
        if (m_dov !== 1'b1 || m_dod !== 32'd204 || m_done !== 1'b0) begin
            failures++;
            $display("FAIL drain_c1 v=%b d=%0d done=%b exp 1 204 0", m_dov, m_dod, m_done);
        end
        tick();
        checks++;
        if (m_dov !== 1'b1 || m_dod !== 32'd100) begin
            failures++;
            $display("FAIL drain_c2 v=%b d=%0d exp 1 100", m_dov, m_dod);
        end
        tick();
        checks++;
        if (m_dov !== 1'b0) begin
            failures++;
            $display("FAIL drain_c3 v=%b exp 0", m_dov);
        end
        den = 0;
        tick();
        checks++;
        if (m_dov !== 1'b0 || t_dov !== 1'b0 || m_done !== 1'b0 || t_done !== 1'b0) begin
            failures++;
            $display("FAIL drain_end mv=%b tv=%b md=%b td=%b exp all 0", m_dov, t_dov, m_done, t_done);
        end
        // tail must start a fresh tile after returning to ACC
        t_vld = 1; t_d0 = 8'd3; t_d1 = 8'd4; t_last = 1;
        tick();
        t_vld = 0; t_last = 0;
        checks++;
        if (t_acc !== 32'd12 || t_done !== 1'b1) begin
            failures++;
            $display("FAIL tail_new_tile acc=%0d done=%b exp 12 1", t_acc, t_done);
        end
    endtask

    task automatic test_signed();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        va = '{8'hFD, 8'h04, 8'hFF};
        vb = '{8'h05, 8'hFE, 8'hFF};
        sm = 1;
        for (int i = 0; i < 3; i++) begin
            m_vld = 1; m_d0 = va[i]; m_d1 = vb[i]; m_last = (i == 2);
            tick();
        end
        m_vld = 0; m_last = 0;
        sm = 0;
        checks++;
        if (m_acc !== 32'hFFFFFFEA || m_sat !== 1'b0 || m_done !== 1'b1) begin
            failures++;
            $display("FAIL signed_tile acc=%h sat=%b done=%b exp ffffffea 0 1", m_acc, m_sat, m_done);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        x_sm = 0;
        drive_x(8'd255, 8'd255, 1'b0);
        drive_x(8'd255, 8'd255, 1'b1);
        checks++;
        if (s_acc !== 16'hFFFF || s_sat !== 1'b1) begin
            failures++;
            $display("FAIL unsigned_clamp acc=%h sat=%b exp ffff 1", s_acc, s_sat);
        end
        checks++;
        if (w_acc !== 16'hFC02 || w_sat !== 1'b1) begin
            failures++;
            $display("FAIL unsigned_wrap acc=%h sat=%b exp fc02 1", w_acc, w_sat);
        end
        do_reset();
        x_sm = 1;
        for (int i = 0; i < 4; i++) drive_x(8'h80, 8'h80, i == 3);
        checks++;
        if (s_acc !== 16'h7FFF || s_sat !== 1'b1) begin
            failures++;
            $display("FAIL signed_clamp_max acc=%h sat=%b exp 7fff 1", s_acc, s_sat);
        end
        checks++;
        if (w_acc !== 16'h0000 || w_sat !== 1'b1) begin
            failures++;
            $display("FAIL signed_wrap_pos acc=%h sat=%b exp 0000 1", w_acc, w_sat);
        end
        do_reset();
        x_sm = 1;
        for (int i = 0; i < 3; i++) drive_x(8'h80, 8'h7F, i == 2);
        checks++;
        if (s_acc !== 16'h8000 || s_sat !== 1'b1) begin
            failures++;
            $display("FAIL signed_clamp_min acc=%h sat=%b exp 8000 1", s_acc, s_sat);
        end
        checks++;
        if (w_acc !== 16'h4180 || w_sat !== 1'b1) begin
            failures++;
            $display("FAIL signed_wrap_neg acc=%h sat=%b exp 4180 1", w_acc, w_sat);
        end
        x_sm = 0;
    endtask

    task automatic test_bubbles_overrun();
        do_reset();
        sm = 0;
        m_vld = 1; m_d0 = 8'd2; m_d1 = 8'd3;
        tick();
        m_vld = 0;
        tick();
        tick();
        checks++;
        if (m_acc !== 32'd6 || m_done !== 1'b0) begin
            failures++;
            $display("FAIL bubble_hold acc=%0d done=%b exp 6 0", m_acc, m_done);
        end
        m_vld = 1; m_d0 = 8'd4; m_d1 = 8'd5; m_last = 1;
        tick();
        m_vld = 0; m_last = 0;
        checks++;
        if (m_acc !== 32'd26 || m_done !== 1'b1 || m_overrun !== 1'b0) begin
            failures++;
            $display("FAIL bubble_tile acc=%0d done=%b ovr=%b exp 26 1 0", m_acc, m_done, m_overrun);
        end
        m_vld = 1; m_d0 = 8'd7; m_d1 = 8'd9;
        tick();
        m_vld = 0;
        checks++;
        if (m_overrun !== 1'b1 || m_acc !== 32'd26 || m_o0 !== 8'd7 || m_o1 !== 8'd9 || m_ov !== 1'b1) begin
            failures++;
            $display("FAIL overrun ovr=%b acc=%0d d0=%0d d1=%0d v=%b exp 1 26 7 9 1", m_overrun, m_acc, m_o0, m_o1, m_ov);
        end
    endtask

    task automatic test_reset_mid_tile();
        do_reset();
        sm = 0;
        for (int k = 1; k <= 3; k++) begin
            m_vld = 1; m_d0 = 8'(k); m_d1 = 8'(k);
            tick();
        end
        checks++;
        if (m_acc !== 32'd14) begin
            failures++;
            $display("FAIL partial_tile acc=%0d exp 14", m_acc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_ov, m_o0, m_o1, m_acc, m_done, m_sat, m_overrun, m_dov, m_dod} !== '0) begin
            failures++;
            $display("FAIL async_reset acc=%0d v=%b d0=%0d exp all 0", m_acc, m_ov, m_o0);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            m_vld = 1; m_d0 = 8'(k); m_d1 = 8'(k); m_last = (k == 8);
            tick();
        end
        m_vld = 0; m_last = 0;
        checks++;
        if (m_acc !== 32'd204 || m_done !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_tile acc=%0d done=%b exp 204 1", m_acc, m_done);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_unsigned_tile();
        test_drain_column();
        test_signed();
        test_saturate();
        test_bubbles_overrun();
        test_reset_mid_tile();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
